// File: rtl/blaster_multi.sv
// rtl/blaster_multi.sv - multi-channel igniter arm/charge/fire sequencer with PWM current regulation
module blaster_multi #(
    parameter int          NCH               = 2,
    parameter int          ADC_BITS          = 12,
    parameter int          ADC_CYCLES        = 16,
    parameter int          ISET_W            = 3,
    parameter int          MARGIN_SHIFT      = 3,
    parameter logic [21:0] DEBOUNCE          = 22'h00_0040,
    parameter logic [23:0] FIRE_TIMEOUT      = 24'h10_0000,
    parameter int          BURN_CONFIRM      = 4,
    parameter int          BURNOUT_VOLTAGE   = 800,
    parameter int          BURNOUT_CURRENT   = 12,
    parameter int          CAP_CURRENT_LIMIT = 3840,
    parameter int          CAP_VOLTAGE_LIMIT = 48,
    parameter int          BLINK_BIT         = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm_button,
    input  logic              fire_button,
    input  logic [NCH-1:0]    cont,
    input  logic              lt3420_done,
    input  logic [ISET_W-1:0] iset,
    input  logic [NCH-1:0]    ad_sdata_v,
    input  logic [NCH-1:0]    ad_sdata_i,
    input  logic [1:0]        ad_sdata_cap,
    output logic              ad_cs,
    output logic              lt3420_charge,
    output logic [NCH-1:0]    pwm,
    output logic              dump,
    output logic              arm_led,
    output logic              cont_led,
    output logic [NCH-1:0]    chan_fired,
    output logic [NCH-1:0]    chan_timeout,
    output logic              ocp_fault,
    output logic [2:0]        state_o
);
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BC_W  = $clog2(BURN_CONFIRM + 1);
    localparam int DIV_W = $clog2(ADC_CYCLES);

    localparam logic [ADC_BITS-1:0] BURN_V  = ADC_BITS'(BURNOUT_VOLTAGE);
    localparam logic [ADC_BITS-1:0] BURN_I  = ADC_BITS'(BURNOUT_CURRENT);
    localparam logic [ADC_BITS-1:0] CAP_ILIM = ADC_BITS'(CAP_CURRENT_LIMIT);
    localparam logic [ADC_BITS-1:0] CAP_VMIN = ADC_BITS'(CAP_VOLTAGE_LIMIT);
    localparam logic [BC_W-1:0]     BURN_N  = BC_W'(BURN_CONFIRM);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CHARGE    = 3'd1,
        S_READY     = 3'd2,
        S_FIRE      = 3'd3,
        S_DISCHARGE = 3'd4,
        S_OCP       = 3'd5
    } state_t;

    state_t              state;
    logic [CH_W-1:0]     ch;
    logic [21:0]         debounce_cnt;
    logic [23:0]         fire_timer;
    logic [BC_W-1:0]     burn_cnt;
    logic                pwm_on;
    logic [DIV_W-1:0]    adc_div;
    logic                adc_valid;
    logic [ADC_BITS-1:0] sh_v, sh_i, sh_vcap, sh_icap;
    logic [ADC_BITS-1:0] vout_h, iout_h, vcap_h, icap_h;
    logic [BLINK_BIT:0]  blink_cnt;

    logic                in_fire, abort, ocp_trip, vcap_low;
    logic                burn_done, time_done, chan_end, last_ch, adv, burn_hit;
    logic                blink;
    logic [ADC_BITS:0]   target, margin, lower, upper;

    assign in_fire   = (state == S_FIRE);
    assign abort     = (debounce_cnt == 22'd0) && !fire_button;
    assign ocp_trip  = adc_valid && (icap_h >= CAP_ILIM);
    assign vcap_low  = adc_valid && (vcap_h < CAP_VMIN);
    assign burn_done = (burn_cnt == BURN_N);
    assign time_done = (fire_timer == FIRE_TIMEOUT - 24'd1);
    assign chan_end  = burn_done || time_done;
    assign last_ch   = (ch == CH_W'(NCH - 1));
    assign adv       = in_fire && !abort && !ocp_trip && !vcap_low && chan_end;
    assign burn_hit  = (vout_h >= BURN_V) && (iout_h <= BURN_I);

    // Regulation window: target in ADC codes (iset amps at 256 codes/amp) +/- a fractional margin.
    assign target = (ADC_BITS + 1)'(iset) << 8;
    assign margin = target >> MARGIN_SHIFT;
    assign lower  = target - margin;
    assign upper  = target + margin;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            ch           <= '0;
            debounce_cnt <= '0;
            fire_timer   <= '0;
            burn_cnt     <= '0;
            pwm_on       <= 1'b0;
            chan_fired   <= '0;
            chan_timeout <= '0;
            ocp_fault    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm_button) state <= S_CHARGE;
                end
                S_CHARGE: begin
                    if (!arm_button)      state <= S_IDLE;
                    else if (lt3420_done) state <= S_READY;
                end
                S_READY: begin
                    if (!arm_button) begin
                        state <= S_IDLE;
                    end else if (fire_button) begin
                        state        <= S_FIRE;
                        ch           <= '0;
                        debounce_cnt <= DEBOUNCE;
                        fire_timer   <= '0;
                        burn_cnt     <= '0;
                        pwm_on       <= 1'b0;
                    end
                end
                S_FIRE: begin
                    if (debounce_cnt != 22'd0) debounce_cnt <= debounce_cnt - 22'd1;
                    fire_timer <= fire_timer + 24'd1;
                    if (adc_valid) begin
                        if (!burn_hit)       burn_cnt <= '0;
                        else if (!burn_done) burn_cnt <= burn_cnt + 1'b1;
                        if (iset == '0)                                  pwm_on <= 1'b0;
                        else if (!pwm_on && ({1'b0, iout_h} <= lower)) pwm_on <= 1'b1;
                        else if (pwm_on && ({1'b0, iout_h} >= upper))  pwm_on <= 1'b0;
                    end
                    if (abort) begin
                        state  <= S_DISCHARGE;
                        pwm_on <= 1'b0;
                    end else if (ocp_trip) begin
                        state     <= S_OCP;
                        ocp_fault <= 1'b1;
                        pwm_on    <= 1'b0;
                    end else if (vcap_low) begin
                        state  <= S_DISCHARGE;
                        pwm_on <= 1'b0;
                    end else if (chan_end) begin
                        if (burn_done) chan_fired[ch]   <= 1'b1;
                        if (time_done) chan_timeout[ch] <= 1'b1;
                        pwm_on <= 1'b0;
                        if (last_ch) begin
                            state <= S_DISCHARGE;
                        end else begin
                            ch         <= ch + 1'b1;
                            fire_timer <= '0;
                            burn_cnt   <= '0;
                        end
                    end
                end
                S_DISCHARGE: state <= S_DISCHARGE;
                S_OCP:       state <= S_OCP;
                default:     state <= S_IDLE;
            endcase
        end
    end

    // ADC frame: strobe at div 0, MSB-first bits at div 2..ADC_BITS+1, hold at ADC_BITS+2.
    always_ff @(posedge clk) begin
        if (reset) begin
            adc_div   <= '0;
            adc_valid <= 1'b0;
            sh_v      <= '0;
            sh_i      <= '0;
            sh_vcap   <= '0;
            sh_icap   <= '0;
            vout_h    <= '0;
            iout_h    <= '0;
            vcap_h    <= '0;
            icap_h    <= '0;
        end else if (!in_fire || adv) begin
            adc_div   <= '0;
            adc_valid <= 1'b0;
        end else begin
            adc_div   <= (adc_div == DIV_W'(ADC_CYCLES - 1)) ? '0 : adc_div + 1'b1;
            adc_valid <= (adc_div == DIV_W'(ADC_BITS + 2));
            if (adc_div >= DIV_W'(2) && adc_div <= DIV_W'(ADC_BITS + 1)) begin
                sh_v    <= {sh_v[ADC_BITS-2:0], ad_sdata_v[ch]};
                sh_i    <= {sh_i[ADC_BITS-2:0], ad_sdata_i[ch]};
                sh_vcap <= {sh_vcap[ADC_BITS-2:0], ad_sdata_cap[1]};
                sh_icap <= {sh_icap[ADC_BITS-2:0], ad_sdata_cap[0]};
            end
            if (adc_div == DIV_W'(ADC_BITS + 2)) begin
                vout_h <= sh_v;
                iout_h <= sh_i;
                vcap_h <= sh_vcap;
                icap_h <= sh_icap;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) blink_cnt <= '0;
        else       blink_cnt <= blink_cnt + 1'b1;
    end

    assign blink         = blink_cnt[BLINK_BIT];
    assign ad_cs         = in_fire && (adc_div == '0);
    assign pwm           = (in_fire && pwm_on) ? (NCH'(1) << ch) : '0;
    assign lt3420_charge = (state == S_CHARGE) || (state == S_READY);
    assign dump          = (state == S_DISCHARGE) || (state == S_OCP);
    assign cont_led      = (|cont) ? blink : 1'b1;
    assign state_o       = state;

    always_comb begin
        arm_led = 1'b0;
        case (state)
            S_READY, S_FIRE:  arm_led = 1'b1;
            S_CHARGE, S_OCP:  arm_led = blink;
            default:          arm_led = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_blaster_multi.sv
// tb/tb_blaster_multi.sv - scoreboard bench for blaster_multi with a serial ADC model
module tb_blaster_multi;
    localparam int NCH   = 2;
    localparam int AB    = 12;
    localparam int ACYC  = 18;
    localparam int FTO   = 600;
    localparam int CHK_K = AB + 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm_button = 1'b0, fire_button = 1'b0, lt3420_done = 1'b0;
    logic [NCH-1:0]    cont = '0;
    logic [2:0]        iset = '0;
    logic [NCH-1:0]    ad_sdata_v = '0, ad_sdata_i = '0;
    logic [1:0]        ad_sdata_cap = '0;
    logic              ad_cs, lt3420_charge, dump, arm_led, cont_led, ocp_fault;
    logic [NCH-1:0]    pwm, chan_fired, chan_timeout;
    logic [2:0]        state_o;

    blaster_multi #(
        .NCH(NCH), .ADC_BITS(AB), .ADC_CYCLES(ACYC), .ISET_W(3), .MARGIN_SHIFT(3),
        .DEBOUNCE(22'd64), .FIRE_TIMEOUT(24'(FTO)), .BURN_CONFIRM(4),
        .BURNOUT_VOLTAGE(800), .BURNOUT_CURRENT(12), .CAP_CURRENT_LIMIT(3840),
        .CAP_VOLTAGE_LIMIT(48), .BLINK_BIT(3)
    ) dut (
        .clk(clk), .reset(reset), .arm_button(arm_button), .fire_button(fire_button),
        .cont(cont), .lt3420_done(lt3420_done), .iset(iset),
        .ad_sdata_v(ad_sdata_v), .ad_sdata_i(ad_sdata_i), .ad_sdata_cap(ad_sdata_cap),
        .ad_cs(ad_cs), .lt3420_charge(lt3420_charge), .pwm(pwm), .dump(dump),
        .arm_led(arm_led), .cont_led(cont_led), .chan_fired(chan_fired),
        .chan_timeout(chan_timeout), .ocp_fault(ocp_fault), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NCH-1:0][AB-1:0] v;
        logic [NCH-1:0][AB-1:0] i;
        logic [AB-1:0]          vcap;
        logic [AB-1:0]          icap;
        logic                   chk;
    } frame_t;

    frame_t         stim_q[$];
    logic [NCH-1:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int v0, input int i0, input int v1, input int i1,
                              input int vcap, input int icap, input logic chk,
                              input logic [NCH-1:0] exp_pwm);
        frame_t f;
        f.v[0] = AB'(v0); f.i[0] = AB'(i0);
        f.v[1] = AB'(v1); f.i[1] = AB'(i1);
        f.vcap = AB'(vcap); f.icap = AB'(icap); f.chk = chk;
        stim_q.push_back(f);
        if (chk) exp_q.push_back(exp_pwm);
    endtask

    // Serial ADC model: latches a frame on ad_cs, shifts MSB-first, scores pwm after the sample lands.
    initial begin
        frame_t dflt, cur;
        int k;
        dflt.v = '0; dflt.i = {NCH{12'd4095}}; dflt.vcap = 12'd4000; dflt.icap = '0; dflt.chk = 1'b0;
        cur = dflt;
        k = 255;
        forever begin
            @(negedge clk);
            if (ad_cs) begin
                k = 0;
                cur = (stim_q.size() > 0) ? stim_q.pop_front() : dflt;
            end else if (k < 255) begin
                k++;
            end
            if (k >= 2 && k <= AB + 1) begin
                for (int c = 0; c < NCH; c++) begin
                    ad_sdata_v[c] = cur.v[c][AB + 1 - k];
                    ad_sdata_i[c] = cur.i[c][AB + 1 - k];
                end
                ad_sdata_cap[1] = cur.vcap[AB + 1 - k];
                ad_sdata_cap[0] = cur.icap[AB + 1 - k];
            end
            if (k == CHK_K && cur.chk) begin
                if (exp_q.size() > 0) check_eq("pwm_frame", 32'(pwm), 32'(exp_q.pop_front()));
                else check_eq("pwm_frame_noexp", 32'd1, 32'd0);
                cur.chk = 1'b0;
            end
        end
    end

    task automatic wait_state(input int s, input string tag);
        int n = 0;
        while (state_o != 3'(s) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(state_o), 32'(s));
    endtask

    task automatic wait_exp_empty(input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || stim_q.size() > 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic blink_seen(input int sel, output logic ok);
        logic s0 = 1'b0, s1 = 1'b0, b;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            b = (sel == 0) ? arm_led : cont_led;
            if (b) s1 = 1'b1; else s0 = 1'b1;
        end
        ok = s0 && s1;
    endtask

    task automatic do_reset();
        reset = 1'b1; arm_button = 1'b0; fire_button = 1'b0; lt3420_done = 1'b0;
        stim_q.delete(); exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic arm_and_fire();
        arm_button = 1'b1;
        @(negedge clk);
        lt3420_done = 1'b1;
        wait_state(2, "reach_ready");
        fire_button = 1'b1;
        wait_state(3, "reach_fire");
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int cnt;
        repeat (3) @(negedge clk);
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_outs", 32'({ad_cs, lt3420_charge, dump, ocp_fault, pwm, chan_fired, chan_timeout}), 32'd0);
        reset = 1'b0;

        // Arm / charge / ready / disarm, LED behaviour
        arm_button = 1'b1;
        @(negedge clk);
        check_eq("charge_state", 32'(state_o), 32'd1);
        check_eq("charge_en", 32'(lt3420_charge), 32'd1);
        blink_seen(0, ok);
        check_eq("arm_led_blink_charge", 32'(ok), 32'd1);
        repeat (60) @(negedge clk);
        check_eq("still_charge", 32'(state_o), 32'd1);
        lt3420_done = 1'b1;
        @(negedge clk);
        check_eq("ready_state", 32'(state_o), 32'd2);
        check_eq("ready_charge_en", 32'(lt3420_charge), 32'd1);
        check_eq("ready_arm_led", 32'(arm_led), 32'd1);
        check_eq("cont_led_ok", 32'(cont_led), 32'd1);
        cont = 2'b10;
        blink_seen(1, ok);
        check_eq("cont_led_blink", 32'(ok), 32'd1);
        cont = '0;
        arm_button = 1'b0;
        @(negedge clk);
        check_eq("disarm_idle", 32'(state_o), 32'd0);
        check_eq("disarm_charge_off", 32'(lt3420_charge), 32'd0);

        // Sequential burnout on both channels, iset=0 holds pwm low
        do_reset();
        iset = 3'd0;
        push_frame(900, 0, 0, 4095, 4000, 0, 1'b1, 2'b00);
        for (int n = 0; n < 3; n++) push_frame(900, 5, 0, 4095, 4000, 0, 1'b1, 2'b00);
        for (int n = 0; n < 4; n++) push_frame(0, 4095, 900, 5, 4000, 0, 1'b1, 2'b00);
        arm_and_fire();
        check_eq("fire_arm_led", 32'(arm_led), 32'd1);
        wait_exp_empty("burn_frames_done");
        wait_state(4, "burn_discharge");
        check_eq("burn_fired", 32'(chan_fired), 32'b11);
        check_eq("burn_no_timeout", 32'(chan_timeout), 32'd0);
        check_eq("burn_dump", 32'(dump), 32'd1);
        check_eq("burn_pwm_off", 32'(pwm), 32'd0);

        // Hysteretic regulation iset=2: lower 448, upper 576, then reset mid-fire
        do_reset();
        iset = 3'd2;
        push_frame(0, 400, 0, 400, 4000, 0, 1'b1, 2'b01);
        push_frame(0, 600, 0, 400, 4000, 0, 1'b1, 2'b00);
        push_frame(0, 470, 0, 400, 4000, 0, 1'b1, 2'b00);
        push_frame(0, 448, 0, 400, 4000, 0, 1'b1, 2'b01);
        push_frame(0, 575, 0, 400, 4000, 0, 1'b1, 2'b01);
        arm_and_fire();
        wait_exp_empty("pwm_frames_done");
        check_eq("pwm_before_reset", 32'(pwm), 32'b01);
        reset = 1'b1;
        @(negedge clk);
        check_eq("reset_pwm_off", 32'(pwm), 32'd0);
        check_eq("reset_state_idle", 32'(state_o), 32'd0);
        reset = 1'b0;

        // Over-current wins over a simultaneous burnout confirmation
        do_reset();
        iset = 3'd0;
        for (int n = 0; n < 3; n++) push_frame(900, 5, 0, 4095, 4000, 3839, 1'b1, 2'b00);
        push_frame(900, 5, 0, 4095, 4000, 3840, 1'b0, 2'b00);
        arm_and_fire();
        wait_state(5, "ocp_state");
        check_eq("ocp_fault", 32'(ocp_fault), 32'd1);
        check_eq("ocp_no_fired", 32'(chan_fired), 32'd0);
        check_eq("ocp_dump", 32'(dump), 32'd1);
        blink_seen(0, ok);
        check_eq("ocp_arm_led_blink", 32'(ok), 32'd1);
        do_reset();
        check_eq("ocp_cleared", 32'({ocp_fault, chan_fired, chan_timeout, dump}), 32'd0);

        // Capacitor voltage floor
        push_frame(0, 4095, 0, 4095, 48, 0, 1'b1, 2'b00);
        push_frame(0, 4095, 0, 4095, 47, 0, 1'b0, 2'b00);
        arm_and_fire();
        wait_exp_empty("vcap_ok_frame");
        check_eq("vcap_48_stays", 32'(state_o), 32'd3);
        wait_state(4, "vcap_low_discharge");
        check_eq("vcap_no_status", 32'({chan_fired, chan_timeout}), 32'd0);

        // Timeout on ch0 with an early release that must not abort, then late release aborts
        do_reset();
        arm_and_fire();
        cnt = 0;
        while (!chan_timeout[0] && cnt < 5000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 10) fire_button = 1'b0;
            if (cnt == 20) fire_button = 1'b1;
        end
        check_eq("timeout_cycles", 32'(cnt), 32'(FTO));
        check_eq("timeout_bits", 32'(chan_timeout), 32'b01);
        check_eq("timeout_still_fire", 32'(state_o), 32'd3);
        check_eq("timeout_no_fired", 32'(chan_fired), 32'd0);
        fire_button = 1'b0;
        @(negedge clk);
        check_eq("late_release_abort", 32'(state_o), 32'd4);
        check_eq("abort_ch1_no_timeout", 32'(chan_timeout), 32'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
